pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter sequencing block for the single-cycle CPU datapath. It holds the current instruction address and computes the next one: either sequential (PC+4) or a PC-relative branch target built from a word-scaled, optionally sign-extended 16-bit immediate. It is structured from the shared primitives `and_gate` (extension sign control), `extender` (immediate widening), `mux_32` (next-PC select) plus two 32-bit adders and a PC register. It sits between instruction fetch and the control unit.

## Interface
- No parameters. Reset vector is fixed at 0x00400020.
- clk  input  1  system clock; the PC register updates on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- nPC_sel  input  1  next-PC select: 0 selects sequential, 1 selects branch target.
- ext  input  1  extension mode for imm16: 1 sign-extends, 0 zero-extends.
- imm16  input  16  branch offset in words, from the instruction.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4 (combinational).
- imm_ext  output  32  extended, word-scaled offset (combinational).
- branch_target  output  32  pc_plus4 + imm_ext (combinational).
- pc_next  output  32  value loaded into pc at the next falling edge (combinational).

## Operation
- Sign bit: sign = ext AND imm16[15], computed with an `and_gate`.
- Extension: imm_ext = {14{sign}, imm16, 2'b00}. The offset is always scaled by 4.
- pc_plus4 = pc + 32'd4.
- branch_target = pc_plus4 + imm_ext.
- Both additions are unsigned modulo 2^32. Carry-out is discarded, and wrap-around past 0xFFFFFFFF is legal and silent.
- pc_next comes from a `mux_32`: src0 = pc_plus4, src1 = branch_target, select = nPC_sel.
- PC register: on each falling clk edge with rst_n high, pc <= pc_next.
- No other state exists. There is no stall or enable, so pc advances on every falling edge.
- If nPC_sel or ext is X/Z, the result is undefined. The bench must drive both to known values.

## Timing
- Reset: rst_n low forces pc = 0x00400020 immediately, without waiting for a clock edge. pc holds that value for as long as rst_n is low, regardless of clk.
- Reset deassertion: the first falling edge after rst_n rises loads pc_next. For example, pc goes from 0x00400020 to 0x00400024 when nPC_sel=0.
- Reset asserted mid-operation takes effect at once. Any pending next-PC value is discarded.
- Derived outputs during reset:
  - pc_plus4 = 0x00400024.
  - imm_ext, branch_target and pc_next track their inputs combinationally.
- Latency:
  - imm_ext, pc_plus4, branch_target and pc_next follow their inputs within the same cycle (zero clocks).
  - pc reflects pc_next one falling edge later.
- Inputs must be stable around each falling edge. Input changes between edges affect only the combinational outputs.

## Test plan
- Reset: drive rst_n=0 with clk idle. Expect pc=0x00400020 and pc_plus4=0x00400024 without any clock edge.
- Sequential: rst_n=1, nPC_sel=0, three falling edges. Expect pc to go 0x00400024, then 0x00400028, then 0x0040002C.
- Forward branch: pc=0x00400020, nPC_sel=1, ext=1, imm16=0x0004. Expect imm_ext=0x00000010 and branch_target=0x00400034. Expect pc=0x00400034 after one falling edge.
- Backward branch (sign extension): pc=0x00400034, nPC_sel=1, ext=1, imm16=0xFFFF. Expect imm_ext=0xFFFFFFFC and branch_target=0x00400034.
- Zero extension: same inputs as the backward branch but ext=0. Expect imm_ext=0x0003FFFC and branch_target=0x00440034.
- Reset mid-run: after several increments, pulse rst_n low between edges. Expect pc=0x00400020 at once. After release, the first falling edge with nPC_sel=0 gives pc=0x00400024.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter sequencing for the single-cycle datapath.
// Holds the current instruction address and selects the next one. The next
// address is either the sequential pc+4 or a pc-relative branch target
// formed from a word-scaled, optionally sign-extended 16-bit offset.

// Two-input AND, used to derive the extension sign bit.
module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

// Widens imm16 to 32 bits and scales it by 4 (word offset to byte offset).
module extender (
    input  logic [15:0] imm16,
    input  logic        sign,
    output logic [31:0] ext_out
);
    assign ext_out = {{14{sign}}, imm16, 2'b00};
endmodule

// 32-bit two-way select: sel=0 picks src0, sel=1 picks src1.
module mux_32 (
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic        sel,
    output logic [31:0] y
);
    assign y = sel ? src1 : src0;
endmodule

// 32-bit unsigned adder; the carry-out is dropped so sums wrap modulo 2^32.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

// Program-counter register. Loads on the falling clock edge so the rest of
// the datapath has the high phase to settle. Reset is asynchronous.
module pc_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d,
    output logic [31:0] q
);
    localparam logic [31:0] RESET_VECTOR = 32'h0040_0020;

    // Falling-edge PC update; reset forces the fixed vector immediately.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VECTOR;
        end else begin
            q <= d;
        end
    end
endmodule

// Top level: wires the primitives into the next-PC path.
module pc_next_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nPC_sel,
    input  logic        ext,
    input  logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] imm_ext,
    output logic [31:0] branch_target,
    output logic [31:0] pc_next
);
    logic sign;

    // Sign extension applies only when ext is set and the offset is negative.
    and_gate u_sign (
        .a (ext),
        .b (imm16[15]),
        .y (sign)
    );

    extender u_ext (
        .imm16   (imm16),
        .sign    (sign),
        .ext_out (imm_ext)
    );

    adder_32 u_inc (
        .a   (pc),
        .b   (32'd4),
        .sum (pc_plus4)
    );

    // The branch offset is relative to the instruction after the branch.
    adder_32 u_branch (
        .a   (pc_plus4),
        .b   (imm_ext),
        .sum (branch_target)
    );

    mux_32 u_sel (
        .src0 (pc_plus4),
        .src1 (branch_target),
        .sel  (nPC_sel),
        .y    (pc_next)
    );

    pc_reg u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pc_next),
        .q     (pc)
    );
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, sequential stepping, forward and
// backward branches, zero extension, address wrap-around and mid-run reset.
module tb_pc_next_unit;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic        nPC_sel;
    logic        ext;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] branch_target;
    logic [31:0] pc_next;

    int total;
    int bad;

    pc_next_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nPC_sel       (nPC_sel),
        .ext           (ext),
        .imm16         (imm16),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .imm_ext       (imm_ext),
        .branch_target (branch_target),
        .pc_next       (pc_next)
    );

    // Clock: held high until clk_run is set, then period 10.
    initial clk = 1'b1;
    always #5 if (clk_run) clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // One falling edge, then sample 1 time unit later; inputs change here too.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        nPC_sel = 1'b0;
        ext = 1'b0;
        imm16 = 16'h0000;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0040_0020) begin
            bad++;
            $display("FAIL reset_pc: got %h required %h", pc, 32'h0040_0020);
        end
        total++;
        if (pc_plus4 !== 32'h0040_0024) begin
            bad++;
            $display("FAIL reset_pc_plus4: got %h required %h", pc_plus4, 32'h0040_0024);
        end
        // Clock runs while reset is held; pc must not move.
        clk_run = 1'b1;
        step();
        step();
        total++;
        if (pc !== 32'h0040_0020) begin
            bad++;
            $display("FAIL reset_hold: got %h required %h", pc, 32'h0040_0020);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0040_0024;
        exp_pc[1] = 32'h0040_0028;
        exp_pc[2] = 32'h0040_002C;
        nPC_sel = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (pc_next !== 32'h0040_0024) begin
            bad++;
            $display("FAIL seq_pc_next: got %h required %h", pc_next, 32'h0040_0024);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pc !== exp_pc[i]) begin
                bad++;
                $display("FAIL seq_step%0d: got %h required %h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_forward_branch();
        // Bring pc back to the vector between edges.
        rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0040_0020) begin
            bad++;
            $display("FAIL fwd_reset: got %h required %h", pc, 32'h0040_0020);
        end
        rst_n = 1'b1;
        nPC_sel = 1'b1;
        ext = 1'b1;
        imm16 = 16'h0004;
        #1;
        total++;
        if (imm_ext !== 32'h0000_0010) begin
            bad++;
            $display("FAIL fwd_imm_ext: got %h required %h", imm_ext, 32'h0000_0010);
        end
        total++;
        if (branch_target !== 32'h0040_0034) begin
            bad++;
            $display("FAIL fwd_target: got %h required %h", branch_target, 32'h0040_0034);
        end
        total++;
        if (pc_next !== 32'h0040_0034) begin
            bad++;
            $display("FAIL fwd_pc_next: got %h required %h", pc_next, 32'h0040_0034);
        end
        step();
        total++;
        if (pc !== 32'h0040_0034) begin
            bad++;
            $display("FAIL fwd_pc: got %h required %h", pc, 32'h0040_0034);
        end
    endtask

    task automatic test_backward_and_zero_ext();
        nPC_sel = 1'b1;
        ext = 1'b1;
        imm16 = 16'hFFFF;
        #1;
        total++;
        if (imm_ext !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL back_imm_ext: got %h required %h", imm_ext, 32'hFFFF_FFFC);
        end
        total++;
        if (branch_target !== 32'h0040_0034) begin
            bad++;
            $display("FAIL back_target: got %h required %h", branch_target, 32'h0040_0034);
        end
        ext = 1'b0;
        #1;
        total++;
        if (imm_ext !== 32'h0003_FFFC) begin
            bad++;
            $display("FAIL zext_imm_ext: got %h required %h", imm_ext, 32'h0003_FFFC);
        end
        total++;
        if (branch_target !== 32'h0044_0034) begin
            bad++;
            $display("FAIL zext_target: got %h required %h", branch_target, 32'h0044_0034);
        end
        // Branch-to-self with sign extension keeps pc in place.
        ext = 1'b1;
        step();
        total++;
        if (pc !== 32'h0040_0034) begin
            bad++;
            $display("FAIL back_pc: got %h required %h", pc, 32'h0040_0034);
        end
    endtask

    task automatic test_back_to_back();
        // Alternate branch +2 words and sequential from 0x00400034.
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0040_0040;
        exp_pc[1] = 32'h0040_0044;
        exp_pc[2] = 32'h0040_0050;
        exp_pc[3] = 32'h0040_0054;
        ext = 1'b1;
        imm16 = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            nPC_sel = (i % 2 == 0);
            step();
            total++;
            if (pc !== exp_pc[i]) begin
                bad++;
                $display("FAIL b2b_step%0d: got %h required %h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_wrap();
        // Largest backward branch (imm_ext=0xFFFE0000) from 0x00400054:
        // each step moves -0x1FFFC; 33 steps cross below zero.
        nPC_sel = 1'b1;
        ext = 1'b1;
        imm16 = 16'h8000;
        #1;
        total++;
        if (imm_ext !== 32'hFFFE_0000) begin
            bad++;
            $display("FAIL wrap_imm_ext: got %h required %h", imm_ext, 32'hFFFE_0000);
        end
        for (int i = 0; i < 33; i++) step();
        // 0x00400054 - 32*0x1FFFC = 0xD4; 0xD8 - 0x20000 wraps to 0xFFFE00D8.
        total++;
        if (pc !== 32'hFFFE_00D8) begin
            bad++;
            $display("FAIL wrap_pc: got %h required %h", pc, 32'hFFFE_00D8);
        end
        // Forward branch that carries past 0xFFFFFFFF.
        ext = 1'b0;
        imm16 = 16'hFFFF;
        #1;
        // 0xFFFE00DC + 0x0003FFFC = 0x1_000200D8 -> 0x000200D8
        total++;
        if (branch_target !== 32'h0002_00D8) begin
            bad++;
            $display("FAIL wrap_target: got %h required %h", branch_target, 32'h0002_00D8);
        end
        step();
        total++;
        if (pc !== 32'h0002_00D8) begin
            bad++;
            $display("FAIL wrap_pc2: got %h required %h", pc, 32'h0002_00D8);
        end
    endtask

    task automatic test_reset_mid_run();
        nPC_sel = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0040_0020) begin
            bad++;
            $display("FAIL mid_reset_pc: got %h required %h", pc, 32'h0040_0020);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (pc !== 32'h0040_0020) begin
            bad++;
            $display("FAIL mid_release_hold: got %h required %h", pc, 32'h0040_0020);
        end
        step();
        total++;
        if (pc !== 32'h0040_0024) begin
            bad++;
            $display("FAIL mid_first_edge: got %h required %h", pc, 32'h0040_0024);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clk_run = 1'b0;
        test_reset();
        test_sequential();
        test_forward_branch();
        test_backward_and_zero_ext();
        test_back_to_back();
        test_wrap();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
